// File: rtl/tile_loader.sv
// tile_loader: ping-pong 4x4 tile buffer between a raster pixel stream and a
// transform controller. One bank fills from the input while the other bank
// presents the last launched tile on tile_data.
// Optional feature: define TILE_LOADER_CNT_EN to add the 16-bit tile_cnt
// output counting launches.
module tile_loader #(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    input  logic                 ctrl_ready,
    output logic                 start,
    output logic [16*DATA_W-1:0] tile_data,
    output logic                 tile_valid
`ifdef TILE_LOADER_CNT_EN
    ,
    output logic [15:0]          tile_cnt
`endif
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        FULL   = 2'd1,
        LAUNCH = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [3:0]         wr_cnt;
    logic               wr_bank;
    logic               rd_bank;
    logic               xfer;
    logic               launch;
    logic [DATA_W-1:0]  bank_mem [2][16];

    // A sample is accepted whenever the loader is not holding a full tile.
    assign xfer   = in_valid && (state != FULL);
    // Launch only happens out of FULL when the controller reports idle.
    assign launch = (state == FULL) && ctrl_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode; FULL is the only state that stalls input.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && (wr_cnt == 4'd15)) begin
                    next_state = FULL;
                end
            end
            FULL: begin
                in_ready = 1'b0;
                if (ctrl_ready) begin
                    next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                in_ready   = 1'b1;
                next_state = FILL;
            end
            default: begin
                in_ready   = 1'b0;
                next_state = FILL;
            end
        endcase
    end

    // Write pointer: advances per sample, parks at 15 when full, rewinds on swap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt <= 4'd0;
        end else if (launch) begin
            wr_cnt <= 4'd0;
        end else if (xfer && (wr_cnt != 4'd15)) begin
            wr_cnt <= wr_cnt + 4'd1;
        end
    end

    // Bank selects swap together at launch so the filled bank becomes visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
        end else if (launch) begin
            wr_bank <= ~wr_bank;
            rd_bank <= ~rd_bank;
        end
    end

    // Registered launch pulse and sticky valid flag for the controller side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start      <= 1'b0;
            tile_valid <= 1'b0;
        end else begin
            start      <= launch;
            tile_valid <= tile_valid | launch;
        end
    end

    // Sample storage; contents are don't-care after reset so no clear is needed.
    always_ff @(posedge clk) begin
        if (rst_n && xfer) begin
            bank_mem[wr_bank][wr_cnt] <= in_data;
        end
    end

    // Present the read bank, forced to zero until the first tile is launched.
    always_comb begin
        tile_data = '0;
        for (int k = 0; k < 16; k++) begin
            tile_data[k*DATA_W +: DATA_W] = tile_valid ? bank_mem[rd_bank][k] : '0;
        end
    end

`ifdef TILE_LOADER_CNT_EN
    // Launch counter, free-running with natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tile_cnt <= 16'd0;
        end else if (launch) begin
            tile_cnt <= tile_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_loader.sv
// tb_tile_loader: directed scenarios plus randomized traffic for tile_loader,
// checked every cycle against a sample-queue reference model.
// Define TILE_LOADER_CNT_EN to also exercise the tile_cnt output.
module tb_tile_loader;

    localparam int DATA_W = 8;
    localparam int TW     = 16 * DATA_W;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ctrl_ready;
    logic              start;
    logic [TW-1:0]     tile_data;
    logic              tile_valid;
`ifdef TILE_LOADER_CNT_EN
    logic [15:0]       tile_cnt;
`endif

    int tests  = 0;
    int errors = 0;

    // Reference model: samples collected so far, completed tile awaiting launch,
    // currently displayed tile.
    logic [DATA_W-1:0] m_fill[$];
    logic [DATA_W-1:0] m_done  [16];
    logic [DATA_W-1:0] m_shown [16];
    bit                m_full;
    bit                m_launch;
    bit                m_valid;
    logic [15:0]       m_cnt;

    tile_loader #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ctrl_ready (ctrl_ready),
        .start      (start),
        .tile_data  (tile_data),
        .tile_valid (tile_valid)
`ifdef TILE_LOADER_CNT_EN
        ,
        .tile_cnt   (tile_cnt)
`endif
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check.
    task automatic checkOutput(input string tag, input logic [TW-1:0] observed,
                               input logic [TW-1:0] expected);
        tests++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model one rising edge with the inputs about to be applied.
    task automatic modelEdge(input logic v, input logic [DATA_W-1:0] d,
                             input logic cr, input logic rn);
        bit accept;
        bit fire;
        if (!rn) begin
            m_fill.delete();
            m_full   = 0;
            m_launch = 0;
            m_valid  = 0;
            m_cnt    = 16'd0;
            return;
        end
        accept = v && !m_full;
        fire   = m_full && cr;
        if (fire) begin
            for (int k = 0; k < 16; k++) m_shown[k] = m_done[k];
            m_valid = 1;
            m_full  = 0;
            m_cnt   = m_cnt + 16'd1;
        end
        if (accept) begin
            m_fill.push_back(d);
            if (m_fill.size() == 16) begin
                for (int k = 0; k < 16; k++) m_done[k] = m_fill[k];
                m_fill.delete();
                m_full = 1;
            end
        end
        m_launch = fire;
    endtask

    // Compare all DUT outputs with the model's current view.
    task automatic checkCycle();
        logic [TW-1:0] exp_tile;
        exp_tile = '0;
        if (m_valid) begin
            for (int k = 0; k < 16; k++) exp_tile[k*DATA_W +: DATA_W] = m_shown[k];
        end
        checkOutput("in_ready",   TW'(in_ready),   TW'(!m_full));
        checkOutput("start",      TW'(start),      TW'(m_launch));
        checkOutput("tile_valid", TW'(tile_valid), TW'(m_valid));
        checkOutput("tile_data",  tile_data,       exp_tile);
`ifdef TILE_LOADER_CNT_EN
        checkOutput("tile_cnt",   TW'(tile_cnt),   TW'(m_cnt));
`endif
    endtask

    // One cycle: check outputs away from the edge, drive inputs, advance model.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic cr, input logic rn);
        @(negedge clk);
        checkCycle();
        in_valid   = v;
        in_data    = d;
        ctrl_ready = cr;
        rst_n      = rn;
        modelEdge(v, d, cr, rn);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int busy;
        int idx;
        int guard;
        logic [DATA_W-1:0] d;
        bit acc;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        ctrl_ready = 1'b0;
        modelEdge(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        $display("[TB] reset state and first tile 0x00..0x0F");
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, DATA_W'(i), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

        $display("[TB] backpressure with 0xAA held");
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, DATA_W'(8'h40 + i), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 1; i < 16; i++) applyStimulus(1'b1, DATA_W'(8'h50 + i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

        $display("[TB] two tiles streamed, controller busy 6 cycles");
        doReset();
        busy  = 0;
        idx   = 0;
        guard = 0;
        while (idx < 32 && guard < 200) begin
            d   = (idx < 16) ? DATA_W'(8'h10 + idx) : DATA_W'(8'h20 + idx - 16);
            acc = !m_full;
            applyStimulus(1'b1, d, (busy == 0), 1'b1);
            if (m_launch) busy = 6;
            else if (busy > 0) busy--;
            if (acc) idx++;
            guard++;
        end
        checkOutput("stream_budget", TW'(idx), TW'(32));
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, '0, (busy == 0), 1'b1);
            if (m_launch) busy = 6;
            else if (busy > 0) busy--;
        end

        $display("[TB] reset mid-tile then clean tile 0x30..0x3F");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, DATA_W'(8'h70 + i), 1'b0, 1'b1);
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, DATA_W'(8'h30 + i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

        $display("[TB] ctrl_ready toggling during fill");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, DATA_W'($urandom), i[0], 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, i[0], 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), DATA_W'($urandom),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 150) != 0));
        end

`ifdef TILE_LOADER_CNT_EN
        $display("[TB] tile counter over three tiles");
        doReset();
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 16; i++) applyStimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
        end
        @(negedge clk);
        checkOutput("tile_cnt_3", TW'(tile_cnt), TW'(3));
        doReset();
`endif

        @(negedge clk);
        checkCycle();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
